// File: rtl/pixel_persistence.sv
// Per-pixel, per-channel saturating intensity integrator with clear sweep and registered display read port.
// Optional macro PIXEL_PERSISTENCE_CHAN_MASK_EN adds a per-channel display mask input (chan_mask).
module pixel_persistence #(
  parameter int ADDR_W = 16,
  parameter int NCH    = 3,
  parameter int INT_W  = 5,
  parameter int INC    = 1,
  parameter int DEC    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [NCH-1:0]         in_bits,
  input  logic [ADDR_W-1:0]      rd_addr,
`ifdef PIXEL_PERSISTENCE_CHAN_MASK_EN
  input  logic [NCH-1:0]         chan_mask,
`endif
  output logic [NCH*INT_W-1:0]   rd_data,
  output logic                   busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = NCH * INT_W;
  localparam logic [INT_W:0] MAX_V = {1'b0, {INT_W{1'b1}}};
  localparam logic [INT_W:0] INC_V = (INT_W+1)'(INC);
  localparam logic [INT_W:0] DEC_V = (INT_W+1)'(DEC);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] sweep_addr, sweep_next;

  logic [DW-1:0]     mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DW-1:0]     wd;

  logic              accept;
  logic              s0_valid, s1_valid;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic [NCH-1:0]    s0_bits, s1_bits;
  logic [DW-1:0]     ram_q, fwd_q, s1_old, s1_new;
  logic              use_fwd;
  logic [INT_W:0]    old_w, new_w;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [DW-1:0]     keep;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_next;
    end
  end

  always_comb begin
    state_next = state;
    sweep_next = sweep_addr;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clear) begin
          sweep_next = '0;
        end else begin
          sweep_next = sweep_addr + 1'b1;
          if (sweep_addr == '1) state_next = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (clear) begin
          state_next = CLEAR;
          sweep_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // A sample accepted alongside clear is dropped with everything already in flight.
  assign accept = in_valid && in_ready && !clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      use_fwd  <= 1'b0;
    end else begin
      s0_valid <= accept;
      s1_valid <= s0_valid && !clear;
      use_fwd  <= s1_valid && (s1_addr == s0_addr);
    end
  end

  always_ff @(posedge clock) begin
    s0_addr <= in_addr;
    s0_bits <= in_bits;
    s1_addr <= s0_addr;
    s1_bits <= s0_bits;
    fwd_q   <= s1_new;
  end

  // The RAM read for S0 misses the write landing on the same edge, so S1's result is forwarded instead.
  assign s1_old = use_fwd ? fwd_q : ram_q;

  always_comb begin
    s1_new = '0;
    old_w  = '0;
    new_w  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      old_w = {1'b0, s1_old[k*INT_W +: INT_W]};
      if (s1_bits[k]) begin
        new_w = old_w + INC_V;
        if (new_w > MAX_V) new_w = MAX_V;
      end else begin
        new_w = (old_w >= DEC_V) ? (old_w - DEC_V) : '0;
      end
      s1_new[k*INT_W +: INT_W] = new_w[INT_W-1:0];
    end
  end

  always_comb begin
    we = 1'b0;
    wa = s1_addr;
    wd = s1_new;
    if (!reset) begin
      if (state == CLEAR) begin
        we = 1'b1;
        wa = sweep_addr;
        wd = '0;
      end else begin
        we = s1_valid && !clear;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    ram_q <= mem[s0_addr];
  end

`ifdef PIXEL_PERSISTENCE_CHAN_MASK_EN
  logic [NCH-1:0] mask_q;

  always_ff @(posedge clock) begin
    if (reset) mask_q <= '0;
    else       mask_q <= chan_mask;
  end

  always_comb begin
    keep = '1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (mask_q[k]) keep[k*INT_W +: INT_W] = '0;
    end
  end
`else
  assign keep = '1;
`endif

  always_ff @(posedge clock) begin
    rd_addr_q <= rd_addr;
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr_q] & keep;
  end

endmodule
